dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Two-requester arbiter/sequencer for the 1024x8 DataMemory. Accepts single-beat
//  read/write requests on two ports (p0 = CPU, p1 = DMA), grants one at a time and
//  generates the enable/address sequence the memory needs.
//  Memory contract: address latches on a clock edge when exactly one of WriteEn/ReadEn
//  is high; a write lands at the previously latched address; read data is valid only
//  while ReadEn=1. Every access is therefore SETUP (latch address) then ACCESS.
// PARAMETERS
//  ADDR_W  10  memory address width
//  DATA_W  8   memory data width
// PORTS
//  i_clk          in   1       clock, rising edge
//  i_rst          in   1       asynchronous reset, active-high
//  i_req0/1       in   1       request, held until o_ack0/1
//  i_we0/1        in   1       1=write, 0=read; stable while req high
//  i_addr0/1      in   ADDR_W  request address; stable while req high
//  i_wdata0/1     in   DATA_W  write data; stable while req high
//  o_ack0/1       out  1       one-cycle completion pulse
//  o_rdata0/1     out  DATA_W  read data; valid with ack, held until next read on that port
//  o_mem_Address  out  ADDR_W  to DataMemory i_Address
//  o_mem_WriteData out DATA_W  to DataMemory i_WriteData
//  o_mem_WriteEn  out  1       to DataMemory i_WriteEn
//  o_mem_ReadEn   out  1       to DataMemory i_ReadEn
//  i_mem_ReadData in   DATA_W  from DataMemory o_ReadData
//  o_busy         out  1       state != IDLE
//  o_grant        out  1       port owning current transaction (0/1)
// BEHAVIOUR
//  - FSM: IDLE -> SETUP -> ACCESS -> DONE -> IDLE; 4 cycles per transaction.
//  - IDLE: if any req, pick winner, register its we/addr/wdata, set o_grant -> SETUP.
//  - SETUP: mem ReadEn=1, WriteEn=0, Address=latched addr (pointer loads at edge).
//  - ACCESS read: ReadEn=1, WriteEn=0; i_mem_ReadData captured into o_rdataN at edge.
//  - ACCESS write: WriteEn=1, ReadEn=1 (pointer held), WriteData=latched data.
//  - DONE: o_ackN=1 for granted port only; enables 0 -> IDLE.
//  - Latency: req sampled in IDLE at edge E0 -> ack high in cycle after E2.
//  - Mem enables/address decoded from registered state; 0 in IDLE/DONE; Address=0 when idle.
//  - Req still high in cycle after ack = new transaction; re-arbitrated in IDLE.
//  - Request fields sampled once in IDLE; later changes ignored until ack.
//  - Req dropped before ack: transaction still completes and acks (protocol violation tolerated).
//  - Address not modified: 0x3FF and 0x000 pass through unchanged, no wrap logic.
//  - Reset (any state, async): state=IDLE, all acks/enables=0, o_grant=0, o_busy=0,
//    o_rdata0/1=0, RR pointer=1; write in ACCESS aborted with enables dropping at once.
// CONFIGURATION
//  DMEM_ARB_RR_EN defined: round-robin; both req in IDLE -> port != last granted wins;
//    last-granted updated on each grant; after reset port 0 wins first tie.
//  Undefined: fixed priority, port 0 always wins ties; p1 may starve.
// TESTING
//  - p0 write 0x2A5<=0x5C, then p0 read 0x2A5 -> ack0 4 cycles each, rdata0=0x5C.
//  - Check seq for write: SETUP RE=1/WE=0 addr=0x2A5; ACCESS RE=1/WE=1 data=0x5C.
//  - RR_EN: req0,req1 held high continuously -> grants 0,1,0,1; acks alternate.
//  - No RR_EN: same stimulus -> only ack0 pulses every 4 cycles; ack1 never.
//  - p1 write 0x3FF<=0xFF, p0 write 0x000<=0x11, read both back -> 0xFF, 0x11.
//  - Reset during ACCESS of write 0x010<=0xAA (prior 0x33) -> enables 0 immediately,
//    no ack, readback of 0x010 = 0x33; o_busy=0 until next req.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port (CPU/DMA) single-beat arbiter and SETUP/ACCESS sequencer for the 1024x8 DataMemory.
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module dmem_arbiter #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_req0,
   input  logic              i_we0,
   input  logic [ADDR_W-1:0] i_addr0,
   input  logic [DATA_W-1:0] i_wdata0,
   output logic              o_ack0,
   output logic [DATA_W-1:0] o_rdata0,
   input  logic              i_req1,
   input  logic              i_we1,
   input  logic [ADDR_W-1:0] i_addr1,
   input  logic [DATA_W-1:0] i_wdata1,
   output logic              o_ack1,
   output logic [DATA_W-1:0] o_rdata1,
   output logic [ADDR_W-1:0] o_mem_Address,
   output logic [DATA_W-1:0] o_mem_WriteData,
   output logic              o_mem_WriteEn,
   output logic              o_mem_ReadEn,
   input  logic [DATA_W-1:0] i_mem_ReadData,
   output logic              o_busy,
   output logic              o_grant
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

   state_t            state_reg, state_next;
   logic              grant_reg;
   logic              we_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [DATA_W-1:0] wdata_reg;
   logic [DATA_W-1:0] rdata0_reg, rdata1_reg;
   logic              winner;
   logic              any_req;

   assign any_req = i_req0 | i_req1;

`ifdef DMEM_ARB_RR_EN
   logic last_reg;
   // On a tie the port that was not granted last time wins.
   assign winner = (i_req0 & i_req1) ? ~last_reg : i_req1;
`else
   assign winner = ~i_req0;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_reg  <= IDLE;
         grant_reg  <= 1'b0;
         we_reg     <= 1'b0;
         addr_reg   <= '0;
         wdata_reg  <= '0;
         rdata0_reg <= '0;
         rdata1_reg <= '0;
`ifdef DMEM_ARB_RR_EN
         last_reg   <= 1'b1;
`endif
      end else begin
         state_reg <= state_next;
         // Request fields are captured once; later changes are ignored until ack.
         if (state_reg == IDLE && any_req) begin
            grant_reg <= winner;
            we_reg    <= winner ? i_we1    : i_we0;
            addr_reg  <= winner ? i_addr1  : i_addr0;
            wdata_reg <= winner ? i_wdata1 : i_wdata0;
`ifdef DMEM_ARB_RR_EN
            last_reg  <= winner;
`endif
         end
         if (state_reg == ACCESS && !we_reg) begin
            if (grant_reg) rdata1_reg <= i_mem_ReadData;
            else           rdata0_reg <= i_mem_ReadData;
         end
      end
   end

   always_comb begin
      state_next      = state_reg;
      o_mem_ReadEn    = 1'b0;
      o_mem_WriteEn   = 1'b0;
      o_mem_Address   = '0;
      o_mem_WriteData = '0;
      o_ack0          = 1'b0;
      o_ack1          = 1'b0;
      case (state_reg)
         IDLE: begin
            if (any_req) state_next = SETUP;
         end
         SETUP: begin
            // ReadEn alone latches the memory's address pointer at the edge.
            o_mem_ReadEn  = 1'b1;
            o_mem_Address = addr_reg;
            state_next    = ACCESS;
         end
         ACCESS: begin
            // Both enables high on a write keeps the pointer from reloading.
            o_mem_ReadEn    = 1'b1;
            o_mem_WriteEn   = we_reg;
            o_mem_Address   = addr_reg;
            o_mem_WriteData = we_reg ? wdata_reg : '0;
            state_next      = DONE;
         end
         DONE: begin
            o_ack0     = ~grant_reg;
            o_ack1     = grant_reg;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign o_busy   = (state_reg != IDLE);
   assign o_grant  = grant_reg;
   assign o_rdata0 = rdata0_reg;
   assign o_rdata1 = rdata1_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural DataMemory, reference memory contents and a
// grant-order model; directed protocol cases followed by randomized contention.
module tb_dmem_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0, we0, req1, we1;
   logic [9:0] addr0, addr1;
   logic [7:0] wdata0, wdata1;
   logic       ack0, ack1, busy, grant;
   logic [7:0] rdata0, rdata1;
   logic [9:0] mem_addr;
   logic [7:0] mem_wdata, mem_rdata;
   logic       mem_we, mem_re;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(10), .DATA_W(8)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_req0(req0), .i_we0(we0), .i_addr0(addr0), .i_wdata0(wdata0),
      .o_ack0(ack0), .o_rdata0(rdata0),
      .i_req1(req1), .i_we1(we1), .i_addr1(addr1), .i_wdata1(wdata1),
      .o_ack1(ack1), .o_rdata1(rdata1),
      .o_mem_Address(mem_addr), .o_mem_WriteData(mem_wdata),
      .o_mem_WriteEn(mem_we), .o_mem_ReadEn(mem_re),
      .i_mem_ReadData(mem_rdata),
      .o_busy(busy), .o_grant(grant)
   );

   // DataMemory behaviour: pointer loads when exactly one enable is high,
   // writes land at the latched pointer, read data only while ReadEn is high.
   logic [7:0] mem [1024];
   logic [9:0] ptr;
   logic       mem_init;
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 8'(i) ^ 8'hA5;
         ptr <= '0;
      end else begin
         if (mem_we ^ mem_re) ptr <= mem_addr;
         if (mem_we) mem[ptr] <= mem_wdata;
      end
   end
   assign mem_rdata = mem_re ? mem[ptr] : 8'h00;

   logic [7:0] ref_mem [1024];
   logic       f_we    [2];
   logic [9:0] f_addr  [2];
   logic [7:0] f_wdata [2];
   int         last_grant;
   int         checks   = 0;
   int         failures = 0;

`ifdef DMEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int p);
      if (p == 0) begin req0 = 1'b1; we0 = f_we[0]; addr0 = f_addr[0]; wdata0 = f_wdata[0]; end
      else        begin req1 = 1'b1; we1 = f_we[1]; addr1 = f_addr[1]; wdata1 = f_wdata[1]; end
   endtask

   // Runs every transaction in mask to completion, checking the 4-cycle sequence.
   task automatic run_txn(input logic [1:0] mask);
      logic [1:0] pending;
      logic [7:0] rd;
      int         w;
      pending = mask;
      if (mask[0]) drive(0);
      if (mask[1]) drive(1);
      while (pending != 2'b00) begin
         if (pending == 2'b11) w = (RR && last_grant == 0) ? 1 : 0;
         else                  w = pending[1] ? 1 : 0;
         last_grant = w;
         @(negedge clk);
         chk("setup_busy", 16'(busy), 16'd1);
         chk("setup_grant", 16'(grant), 16'(w));
         chk("setup_re", 16'(mem_re), 16'd1);
         chk("setup_we", 16'(mem_we), 16'd0);
         chk("setup_addr", 16'(mem_addr), 16'(f_addr[w]));
         // Fields change after sampling; the arbiter must ignore them.
         if (w == 0) begin we0 = ~we0; addr0 = 10'($urandom); wdata0 = 8'($urandom); end
         else        begin we1 = ~we1; addr1 = 10'($urandom); wdata1 = 8'($urandom); end
         @(negedge clk);
         chk("access_re", 16'(mem_re), 16'd1);
         chk("access_we", 16'(mem_we), 16'(f_we[w]));
         chk("access_addr", 16'(mem_addr), 16'(f_addr[w]));
         if (f_we[w]) chk("access_wdata", 16'(mem_wdata), 16'(f_wdata[w]));
         @(negedge clk);
         chk("done_ack0", 16'(ack0), 16'(w == 0));
         chk("done_ack1", 16'(ack1), 16'(w == 1));
         chk("done_en", 16'({mem_re, mem_we}), 16'd0);
         chk("done_addr", 16'(mem_addr), 16'd0);
         rd = (w == 0) ? rdata0 : rdata1;
         if (f_we[w]) ref_mem[f_addr[w]] = f_wdata[w];
         else         chk("rdata", 16'(rd), 16'(ref_mem[f_addr[w]]));
         $display("txn port=%0d we=%0d addr=%03h wdata=%02h rdata=%02h", w, f_we[w],
                  f_addr[w], f_wdata[w], rd);
         if (w == 0) req0 = 1'b0; else req1 = 1'b0;
         pending[w] = 1'b0;
         @(negedge clk);
         chk("idle_busy", 16'(busy), 16'd0);
      end
   endtask

   initial begin
      rst = 1'b1; mem_init = 1'b1;
      req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
      req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
      for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i) ^ 8'hA5;
      last_grant = 1;
      @(negedge clk); @(negedge clk);
      mem_init = 1'b0;
      chk("rst_busy", 16'(busy), 16'd0);
      chk("rst_grant", 16'(grant), 16'd0);
      chk("rst_acks", 16'({ack0, ack1}), 16'd0);
      chk("rst_en", 16'({mem_re, mem_we}), 16'd0);
      chk("rst_addr", 16'(mem_addr), 16'd0);
      chk("rst_rdata", 16'({rdata0, rdata1}), 16'd0);
      rst = 1'b0;
      @(negedge clk);

      // Both requests held continuously across four transactions.
      f_we[0] = 0; f_addr[0] = 10'h100; f_wdata[0] = 0;
      f_we[1] = 0; f_addr[1] = 10'h200; f_wdata[1] = 0;
      drive(0); drive(1);
      for (int k = 0; k < 4; k++) begin
         int w;
         w = RR ? (k % 2) : 0;
         @(negedge clk);
         chk("hold_grant", 16'(grant), 16'(w));
         @(negedge clk);
         @(negedge clk);
         chk("hold_ack0", 16'(ack0), 16'(w == 0));
         chk("hold_ack1", 16'(ack1), 16'(w == 1));
         chk("hold_rdata", 16'(w == 0 ? rdata0 : rdata1), 16'(ref_mem[f_addr[w]]));
         $display("txn hold k=%0d port=%0d ack0=%0d ack1=%0d", k, w, ack0, ack1);
         last_grant = w;
         if (k == 3) begin req0 = 1'b0; req1 = 1'b0; end
         @(negedge clk);
         chk("hold_idle", 16'(busy), 16'd0);
      end

      f_we[0] = 1; f_addr[0] = 10'h2A5; f_wdata[0] = 8'h5C;
      run_txn(2'b01);
      f_we[0] = 0;
      run_txn(2'b01);
      chk("rd_2a5", 16'(rdata0), 16'h5C);

      f_we[1] = 1; f_addr[1] = 10'h3FF; f_wdata[1] = 8'hFF;
      run_txn(2'b10);
      f_we[0] = 1; f_addr[0] = 10'h000; f_wdata[0] = 8'h11;
      run_txn(2'b01);
      f_we[1] = 0; run_txn(2'b10);
      chk("rd_3ff", 16'(rdata1), 16'hFF);
      f_we[0] = 0; run_txn(2'b01);
      chk("rd_000", 16'(rdata0), 16'h11);

      // Reset arriving mid-write must abort it.
      f_we[0] = 1; f_addr[0] = 10'h010; f_wdata[0] = 8'h33;
      run_txn(2'b01);
      f_wdata[0] = 8'hAA;
      drive(0);
      @(negedge clk);
      @(negedge clk);
      chk("abort_pre_we", 16'(mem_we), 16'd1);
      #1 rst = 1'b1; req0 = 1'b0;
      #1;
      chk("abort_en", 16'({mem_re, mem_we}), 16'd0);
      chk("abort_busy", 16'(busy), 16'd0);
      chk("abort_ack", 16'({ack0, ack1}), 16'd0);
      chk("abort_grant", 16'(grant), 16'd0);
      chk("abort_rdata", 16'({rdata0, rdata1}), 16'd0);
      @(negedge clk);
      rst = 1'b0;
      last_grant = 1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("post_rst_busy", 16'(busy), 16'd0);
         chk("post_rst_ack", 16'({ack0, ack1}), 16'd0);
      end
      f_we[0] = 0; run_txn(2'b01);
      chk("rd_010", 16'(rdata0), 16'h33);
      $display("txn reset_abort readback=%02h", rdata0);

      for (int n = 0; n < 40; n++) begin
         for (int p = 0; p < 2; p++) begin
            f_we[p]    = 1'($urandom);
            f_addr[p]  = 10'h3E0 | 10'($urandom_range(0, 31));
            f_wdata[p] = 8'($urandom);
         end
         run_txn(2'($urandom_range(1, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
